project_mux_ctrl: RTL and testbench
===================================

PROJECT_MUX_CTRL -- requirements
Module: project_mux_ctrl

Interface
REQ-001 The module SHALL have parameter NUM_PROJ, default 8, meaning the number of hosted projects (2..16).
REQ-002 The module SHALL have parameter IO_W, default 38, meaning the pad count.
REQ-003 The module SHALL have parameter BASE_ADDR, default 32'h0310_0000, meaning the control register base.
REQ-004 The module SHALL have parameter HOLD_CYC, default 16, meaning the reset hold cycles per switch phase (>=1).
REQ-005 The module SHALL have port wb_clk_i, input, 1 bit: the single clock.
REQ-006 The module SHALL have port wb_rst_i, input, 1 bit: reset; asynchronous, active-high.
REQ-007 The module SHALL have ports wbs_cyc_i, wbs_stb_i and wbs_we_i, inputs, 1 bit each: Wishbone slave controls.
REQ-008 The module SHALL have ports wbs_sel_i (input, 4), wbs_adr_i (input, 32) and wbs_dat_i (input, 32): Wishbone byte-select, address and write data.
REQ-009 The module SHALL have ports wbs_ack_o (output, 1) and wbs_dat_o (output, 32): Wishbone acknowledge and read data.
REQ-010 The module SHALL have port proj_rdata, input, NUM_PROJ*32 bits: per-project readback, project k in bits [32k+31:32k].
REQ-011 The module SHALL have port proj_io_out, input, NUM_PROJ*IO_W bits: per-project pad outputs.
REQ-012 The module SHALL have ports io_out and io_oeb, outputs, IO_W bits each: pad drive and output enable (1 = input).
REQ-013 The module SHALL have ports proj_reset and proj_clk_en, outputs, NUM_PROJ bits each: per-project reset (1 = held) and clock enable.
REQ-014 The module SHALL have port proj_wb_update, output, NUM_PROJ bits: one-cycle write strobe into a project window.

Function
REQ-015 The block SHALL decode registers: ACTIVE @BASE+0x0 (R/W, [3:0]); OEB0 @+0x4 (R/W, pads 31:0); OEB1 @+0x8 (R/W, pads IO_W-1:32); STATUS @+0xC (RO: [3:0] current active, [8] busy).
REQ-016 The block SHALL give project k the window BASE+(k+1)*0x100 .. +0xFF.
REQ-017 Ack: wbs_ack_o SHALL pulse exactly one cycle, registered one cycle after cyc&stb on a decoded address, and SHALL NOT re-pulse while the same strobe is held.
REQ-018 Undecoded addresses SHALL get no ack.
REQ-019 Control-register writes SHALL take effect only when wbs_sel_i==4'hF; others SHALL be acked but ignored.
REQ-020 A write in window k SHALL pulse proj_wb_update[k] for one cycle, coincident with ack.
REQ-021 A read in window k SHALL return proj_rdata slice k, registered with ack.
REQ-022 Reads of unmapped offsets inside the control page SHALL return 0.
REQ-023 Switch FSM states SHALL be RUN, DRAIN, SWAP, RELEASE.
REQ-024 RUN: an ACTIVE write with value < NUM_PROJ and != current SHALL set busy and enter DRAIN.
REQ-025 RUN: a write with value >= NUM_PROJ or equal to current SHALL be ignored.
REQ-026 DRAIN SHALL assert all proj_reset, force io_oeb all-ones and io_out 0, and last HOLD_CYC cycles.
REQ-027 SWAP SHALL last 1 cycle, update the active index and set proj_clk_en one-hot to the new project.
REQ-028 RELEASE SHALL keep the new project's reset for HOLD_CYC cycles with pads still forced, then deassert it, clear busy and return to RUN.
REQ-029 ACTIVE writes while busy SHALL be acked and ignored.
REQ-030 RUN: io_out SHALL equal proj_io_out slice[active], registered (1-cycle latency).
REQ-031 RUN: io_oeb SHALL equal {OEB1,OEB0}[IO_W-1:0].
REQ-032 RUN: non-active projects SHALL hold reset=1 and clk_en=0.
REQ-033 OEB writes SHALL be accepted in any state but applied to pads only in RUN.
REQ-034 Width rule: the hold counter SHALL be $clog2(HOLD_CYC+1) bits, saturating, never wrapping.

Reset
REQ-035 While wb_rst_i=1 (asynchronous): active=0, FSM=RELEASE with counter cleared (project 0 released HOLD_CYC cycles after reset deasserts).
REQ-036 While wb_rst_i=1: OEB0/OEB1 all-ones, io_oeb all-ones, io_out 0.
REQ-037 While wb_rst_i=1: proj_reset all-ones, proj_clk_en = 1 for project 0 only.
REQ-038 While wb_rst_i=1: wbs_ack_o=0, wbs_dat_o=0, proj_wb_update=0.
REQ-039 Reset mid-switch SHALL abort to the reset state with no partial selection retained.

Structure
REQ-040 Shared package: register offsets, window size 0x100, FSM state encoding, STATUS bit positions.
REQ-041 One sub-module: project_wb_decode (address decode, ack generation, readback mux); FSM and pad mux SHALL stay at top.

Verification
REQ-042 Reset release -> io_oeb=all-ones until proj_reset[0] falls at cycle HOLD_CYC+1; STATUS reads 0x000.
REQ-043 Write ACTIVE=3 -> STATUS.busy=1; pads forced 2*HOLD_CYC+1 cycles; then io_out tracks slice 3 one cycle later; STATUS=0x003.
REQ-044 Write ACTIVE=9 (NUM_PROJ=8), then ACTIVE=5 while busy -> both acked, active unchanged.
REQ-045 Write 0xA5 to BASE+0x304 -> proj_wb_update[2] high exactly one cycle with ack; read BASE+0x500 returns proj_rdata slice 4.
REQ-046 Write OEB0=0 with sel=4'h3 -> ignored; with sel=4'hF -> io_oeb[31:0]=0 in RUN.
REQ-047 Assert wb_rst_i during DRAIN -> all outputs at reset values the same cycle; active=0.

Source files
------------

// File: rtl/project_mux_ctrl_pkg.sv
// Shared constants for the project multiplexer: control-register map, project window
// geometry, STATUS bit layout and the project switch state encoding.
package project_mux_ctrl_pkg;

    localparam logic [7:0] OFF_ACTIVE = 8'h00;
    localparam logic [7:0] OFF_OEB0   = 8'h04;
    localparam logic [7:0] OFF_OEB1   = 8'h08;
    localparam logic [7:0] OFF_STATUS = 8'h0C;

    localparam int unsigned WIN_SIZE  = 32'h100;
    localparam int unsigned WIN_SHIFT = $clog2(WIN_SIZE);

    localparam int unsigned STAT_ACTIVE_LSB = 0;
    localparam int unsigned STAT_ACTIVE_W   = 4;
    localparam int unsigned STAT_BUSY_BIT   = 8;

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StDrain   = 2'd1,
        StSwap    = 2'd2,
        StRelease = 2'd3
    } sw_state_e;

endpackage

// File: rtl/project_mux_ctrl_if.sv
// Wishbone slave signal bundle between the bus master and the project multiplexer.
interface project_mux_ctrl_if;

    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );

endinterface

// File: rtl/project_wb_decode.sv
// Wishbone address decode for the control page and project windows: single-pulse ack,
// registered readback mux and per-project write strobes.
module project_wb_decode
    import project_mux_ctrl_pkg::*;
#(
    parameter int unsigned NUM_PROJ  = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0310_0000
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    project_mux_ctrl_if.slave        wb,
    input  logic [3:0]               i_active,
    input  logic [31:0]              i_oeb0,
    input  logic [31:0]              i_oeb1,
    input  logic                     i_busy,
    input  logic [NUM_PROJ*32-1:0]   i_proj_rdata,
    output logic                     o_ctrl_we,
    output logic [7:0]               o_ctrl_off,
    output logic [31:0]              o_ctrl_data,
    output logic [NUM_PROJ-1:0]      o_proj_wb_update
);

    logic [31:0]         w_off;
    logic [31:0]         w_page;
    logic                w_ctrl_hit;
    logic                w_proj_hit;
    logic [3:0]          w_pidx;
    logic                w_req;
    logic                w_held_d;
    logic [31:0]         w_rdata;
    logic [NUM_PROJ-1:0] w_upd;
    logic                r_ack;
    logic                r_held;
    logic [31:0]         r_dat;
    logic [NUM_PROJ-1:0] r_upd;

    assign w_off      = wb.wbs_adr_i - BASE_ADDR;
    assign w_page     = w_off >> WIN_SHIFT;
    assign w_ctrl_hit = (w_page == 32'd0);
    assign w_proj_hit = (w_page >= 32'd1) && (w_page <= 32'(NUM_PROJ));
    assign w_pidx     = 4'(w_page - 32'd1);

    // r_held blocks a second ack until the master drops the strobe.
    assign w_req    = wb.wbs_cyc_i & wb.wbs_stb_i & (w_ctrl_hit | w_proj_hit) & ~r_held;
    assign w_held_d = wb.wbs_cyc_i & wb.wbs_stb_i & (r_held | w_req);

    assign o_ctrl_we   = w_req & wb.wbs_we_i & w_ctrl_hit & (wb.wbs_sel_i == 4'hF);
    assign o_ctrl_off  = w_off[7:0];
    assign o_ctrl_data = wb.wbs_dat_i;

    always_comb begin
        w_rdata = '0;
        w_upd   = '0;
        if (w_ctrl_hit) begin
            case (w_off[7:0])
                OFF_ACTIVE: w_rdata = {28'd0, i_active};
                OFF_OEB0:   w_rdata = i_oeb0;
                OFF_OEB1:   w_rdata = i_oeb1;
                OFF_STATUS: begin
                    w_rdata[STAT_ACTIVE_LSB +: STAT_ACTIVE_W] = i_active;
                    w_rdata[STAT_BUSY_BIT]                    = i_busy;
                end
                default:    w_rdata = '0;
            endcase
        end
        for (int k = 0; k < NUM_PROJ; k++) begin
            if (w_proj_hit && (w_pidx == 4'(k))) begin
                w_rdata  = i_proj_rdata[k*32 +: 32];
                w_upd[k] = w_req & wb.wbs_we_i;
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_ack  <= 1'b0;
            r_held <= 1'b0;
            r_dat  <= '0;
            r_upd  <= '0;
        end else begin
            r_ack  <= w_req;
            r_held <= w_held_d;
            r_dat  <= (w_req & ~wb.wbs_we_i) ? w_rdata : 32'd0;
            r_upd  <= w_upd;
        end
    end

    assign wb.wbs_ack_o     = r_ack;
    assign wb.wbs_dat_o     = r_dat;
    assign o_proj_wb_update = r_upd;

endmodule

// File: rtl/project_mux_ctrl.sv
// Multiplexes NUM_PROJ hosted projects onto a shared pad ring; a switch FSM drains,
// swaps and releases projects under Wishbone control.
module project_mux_ctrl
    import project_mux_ctrl_pkg::*;
#(
    parameter int unsigned NUM_PROJ  = 8,
    parameter int unsigned IO_W      = 38,
    parameter logic [31:0] BASE_ADDR = 32'h0310_0000,
    parameter int unsigned HOLD_CYC  = 16
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_i,
    project_mux_ctrl_if.slave          wb,
    input  logic [NUM_PROJ*32-1:0]     proj_rdata,
    input  logic [NUM_PROJ*IO_W-1:0]   proj_io_out,
    output logic [IO_W-1:0]            io_out,
    output logic [IO_W-1:0]            io_oeb,
    output logic [NUM_PROJ-1:0]        proj_reset,
    output logic [NUM_PROJ-1:0]        proj_clk_en,
    output logic [NUM_PROJ-1:0]        proj_wb_update
);

    localparam int unsigned CNT_W = $clog2(HOLD_CYC + 1);

    sw_state_e           r_state, w_state_d;
    logic [CNT_W-1:0]    r_cnt, w_cnt_d;
    logic [3:0]          r_active, w_active_d;
    logic [3:0]          r_target, w_target_d;
    logic [31:0]         r_oeb0, r_oeb1;
    logic [IO_W-1:0]     r_io_out;
    logic [IO_W-1:0]     w_io_slice;
    logic [63:0]         w_oeb_all;
    logic [NUM_PROJ-1:0] w_sel_oh;
    logic                w_ctrl_we;
    logic [7:0]          w_ctrl_off;
    logic [31:0]         w_ctrl_data;
    logic                w_act_wr;
    logic                w_hold_done;
    logic                w_run;

    project_wb_decode #(
        .NUM_PROJ  (NUM_PROJ),
        .BASE_ADDR (BASE_ADDR)
    ) u_decode (
        .wb_clk_i         (wb_clk_i),
        .wb_rst_i         (wb_rst_i),
        .wb               (wb),
        .i_active         (r_active),
        .i_oeb0           (r_oeb0),
        .i_oeb1           (r_oeb1),
        .i_busy           (~w_run),
        .i_proj_rdata     (proj_rdata),
        .o_ctrl_we        (w_ctrl_we),
        .o_ctrl_off       (w_ctrl_off),
        .o_ctrl_data      (w_ctrl_data),
        .o_proj_wb_update (proj_wb_update)
    );

    assign w_run       = (r_state == StRun);
    assign w_act_wr    = w_ctrl_we && (w_ctrl_off == OFF_ACTIVE);
    assign w_hold_done = (r_cnt == CNT_W'(HOLD_CYC - 1));

    always_comb begin
        w_state_d  = r_state;
        w_active_d = r_active;
        w_target_d = r_target;
        w_cnt_d    = (r_cnt == CNT_W'(HOLD_CYC)) ? r_cnt : r_cnt + 1'b1;
        unique case (r_state)
            StRun: begin
                if (w_act_wr && (w_ctrl_data < 32'(NUM_PROJ)) && (w_ctrl_data[3:0] != r_active)) begin
                    w_state_d  = StDrain;
                    w_target_d = w_ctrl_data[3:0];
                    w_cnt_d    = '0;
                end
            end
            StDrain: begin
                if (w_hold_done) begin
                    w_state_d = StSwap;
                    w_cnt_d   = '0;
                end
            end
            StSwap: begin
                w_state_d  = StRelease;
                w_active_d = r_target;
                w_cnt_d    = '0;
            end
            StRelease: begin
                if (w_hold_done) begin
                    w_state_d = StRun;
                end
            end
            default: w_state_d = StRun;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state  <= StRelease;
            r_cnt    <= '0;
            r_active <= '0;
            r_target <= '0;
            r_io_out <= '0;
        end else begin
            r_state  <= w_state_d;
            r_cnt    <= w_cnt_d;
            r_active <= w_active_d;
            r_target <= w_target_d;
            r_io_out <= w_run ? w_io_slice : '0;
        end
    end

    // OEB values are stored in any state; they only reach the pads in RUN.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_oeb0 <= '1;
            r_oeb1 <= '1;
        end else if (w_ctrl_we) begin
            if (w_ctrl_off == OFF_OEB0) r_oeb0 <= w_ctrl_data;
            if (w_ctrl_off == OFF_OEB1) r_oeb1 <= w_ctrl_data;
        end
    end

    always_comb begin
        w_sel_oh   = '0;
        w_io_slice = '0;
        for (int k = 0; k < NUM_PROJ; k++) begin
            if (r_active == 4'(k)) begin
                w_sel_oh[k] = 1'b1;
                w_io_slice  = proj_io_out[k*IO_W +: IO_W];
            end
        end
    end

    assign w_oeb_all   = {r_oeb1, r_oeb0};
    assign io_oeb      = w_run ? w_oeb_all[IO_W-1:0] : '1;
    assign io_out      = r_io_out;
    assign proj_reset  = w_run ? ~w_sel_oh : '1;
    assign proj_clk_en = w_sel_oh;

endmodule

// File: tb/tb_project_mux_ctrl.sv
// Directed bench for project_mux_ctrl: bus transactions feed a scoreboard queue that a
// negedge monitor drains on every ack; pad and reset behaviour is checked inline.
module tb_project_mux_ctrl;

    localparam int unsigned NP   = 8;
    localparam int unsigned IOW  = 38;
    localparam int unsigned H    = 8;
    localparam logic [31:0] BASE = 32'h0310_0000;

    typedef struct {
        logic        is_rd;
        logic [31:0] dat;
        logic [7:0]  upd;
    } exp_t;

    logic              clk;
    logic              rst;
    logic [NP*32-1:0]  proj_rdata;
    logic [NP*IOW-1:0] proj_io_out;
    logic [IOW-1:0]    io_out;
    logic [IOW-1:0]    io_oeb;
    logic [NP-1:0]     proj_reset;
    logic [NP-1:0]     proj_clk_en;
    logic [NP-1:0]     proj_wb_update;

    int    n_cmp = 0;
    int    n_err = 0;
    int    cyc_cnt = 0;
    int    ack_cyc = 0;
    exp_t  exp_q[$];
    string name_q[$];

    project_mux_ctrl_if wbm ();

    project_mux_ctrl #(
        .NUM_PROJ  (NP),
        .IO_W      (IOW),
        .BASE_ADDR (BASE),
        .HOLD_CYC  (H)
    ) dut (
        .wb_clk_i       (clk),
        .wb_rst_i       (rst),
        .wb             (wbm),
        .proj_rdata     (proj_rdata),
        .proj_io_out    (proj_io_out),
        .io_out         (io_out),
        .io_oeb         (io_oeb),
        .proj_reset     (proj_reset),
        .proj_clk_en    (proj_clk_en),
        .proj_wb_update (proj_wb_update)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [IOW-1:0] io_pat(input int k);
        return {6'(k + 1), 32'hC0DE_0000 + 32'(k)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Scoreboard monitor: pops one expectation per ack and enforces one-cycle ack pulses.
    initial begin
        logic  prev_ack;
        exp_t  e;
        string nm;
        prev_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_ack = 1'b0;
            end else begin
                if (prev_ack) begin
                    n_cmp++;
                    if (wbm.wbs_ack_o || (proj_wb_update != '0)) begin
                        n_err++;
                        $display("FAIL ack_one_cycle: ack=%0b upd=0x%0h expected 0/0",
                                 wbm.wbs_ack_o, proj_wb_update);
                    end
                end else if (wbm.wbs_ack_o) begin
                    ack_cyc = cyc_cnt;
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_ack: ack=1 expected no ack");
                    end else begin
                        e  = exp_q.pop_front();
                        nm = name_q.pop_front();
                        if (e.is_rd) begin
                            n_cmp++;
                            if (wbm.wbs_dat_o !== e.dat) begin
                                n_err++;
                                $display("FAIL %s_dat: got 0x%0h expected 0x%0h", nm,
                                         wbm.wbs_dat_o, e.dat);
                            end
                        end
                        n_cmp++;
                        if (proj_wb_update !== e.upd) begin
                            n_err++;
                            $display("FAIL %s_upd: got 0x%0h expected 0x%0h", nm,
                                     proj_wb_update, e.upd);
                        end
                    end
                end else if (proj_wb_update != '0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL upd_without_ack: got 0x%0h expected 0", proj_wb_update);
                end
                prev_ack = wbm.wbs_ack_o;
            end
        end
    end

    task automatic bus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input logic [31:0] exp_dat,
                       input logic [7:0] exp_upd, input string name);
        exp_t e;
        logic got;
        @(negedge clk);
        wbm.wbs_cyc_i = 1'b1;
        wbm.wbs_stb_i = 1'b1;
        wbm.wbs_we_i  = we;
        wbm.wbs_adr_i = adr;
        wbm.wbs_dat_i = dat;
        wbm.wbs_sel_i = sel;
        e.is_rd = ~we;
        e.dat   = exp_dat;
        e.upd   = exp_upd;
        exp_q.push_back(e);
        name_q.push_back(name);
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk);
            #1;
            got = wbm.wbs_ack_o;
        end
        if (!got) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_ack: got no ack expected ack within 8 cycles", name);
            void'(exp_q.pop_back());
            void'(name_q.pop_back());
        end
        // Hold the strobe past the ack so a re-pulse would be seen.
        repeat (2) @(posedge clk);
        @(negedge clk);
        wbm.wbs_cyc_i = 1'b0;
        wbm.wbs_stb_i = 1'b0;
        wbm.wbs_we_i  = 1'b0;
    endtask

    task automatic bus_noack(input logic [31:0] adr, input string name);
        logic seen;
        @(negedge clk);
        wbm.wbs_cyc_i = 1'b1;
        wbm.wbs_stb_i = 1'b1;
        wbm.wbs_we_i  = 1'b0;
        wbm.wbs_adr_i = adr;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            seen = seen | wbm.wbs_ack_o;
        end
        check(name, 64'(seen), 64'd0);
        @(negedge clk);
        wbm.wbs_cyc_i = 1'b0;
        wbm.wbs_stb_i = 1'b0;
    endtask

    task automatic wait_unforced(output int cyc_seen);
        logic done;
        done     = 1'b0;
        cyc_seen = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (io_oeb[31:0] == 32'd0) begin
                done     = 1'b1;
                cyc_seen = cyc_cnt;
            end
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL switch_done: pads still forced expected release within 200 cycles");
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_io_oeb"}, 64'(io_oeb), 64'(38'h3F_FFFF_FFFF));
        check({pfx, "_io_out"}, 64'(io_out), 64'd0);
        check({pfx, "_proj_reset"}, 64'(proj_reset), 64'hFF);
        check({pfx, "_clk_en"}, 64'(proj_clk_en), 64'h01);
        check({pfx, "_ack"}, 64'(wbm.wbs_ack_o), 64'd0);
        check({pfx, "_dat"}, 64'(wbm.wbs_dat_o), 64'd0);
        check({pfx, "_upd"}, 64'(proj_wb_update), 64'd0);
    endtask

    initial begin
        int t0;
        int t1;
        rst = 1'b1;
        wbm.wbs_cyc_i = 1'b0;
        wbm.wbs_stb_i = 1'b0;
        wbm.wbs_we_i  = 1'b0;
        wbm.wbs_sel_i = 4'h0;
        wbm.wbs_adr_i = '0;
        wbm.wbs_dat_i = '0;
        for (int k = 0; k < NP; k++) begin
            proj_rdata[k*32 +: 32]   = 32'hDA7A_0000 + 32'(k);
            proj_io_out[k*IOW +: IOW] = io_pat(k);
        end
        #3;
        check_reset_outputs("rst");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Project 0 leaves reset after exactly H edges.
        for (int i = 1; i <= H; i++) begin
            @(posedge clk);
            #1;
            if (i == H - 1) begin
                check("rel_hold_reset", 64'(proj_reset), 64'hFF);
                check("rel_hold_oeb", 64'(io_oeb), 64'(38'h3F_FFFF_FFFF));
            end
        end
        check("rel_done_reset", 64'(proj_reset), 64'hFE);
        check("rel_done_clk_en", 64'(proj_clk_en), 64'h01);
        @(posedge clk);
        #1;
        check("run_io_out_p0", 64'(io_out), 64'(io_pat(0)));

        bus(1'b0, BASE + 32'h0C, 32'd0, 4'hF, 32'h0000_0000, 8'h00, "status_init");
        bus(1'b0, BASE + 32'h00, 32'd0, 4'hF, 32'h0000_0000, 8'h00, "active_init");
        bus(1'b0, BASE + 32'h04, 32'd0, 4'hF, 32'hFFFF_FFFF, 8'h00, "oeb0_init");
        bus(1'b0, BASE + 32'h08, 32'd0, 4'hF, 32'hFFFF_FFFF, 8'h00, "oeb1_init");
        bus(1'b0, BASE + 32'hF0, 32'd0, 4'hF, 32'h0000_0000, 8'h00, "ctrl_unmapped");
        bus_noack(BASE + 32'h900, "noack_page9");
        bus_noack(32'h0400_0000, "noack_far");

        // Partial byte-select write to OEB0 is acked but has no effect.
        bus(1'b1, BASE + 32'h04, 32'h0, 4'h3, 32'h0, 8'h00, "oeb0_sel3");
        bus(1'b0, BASE + 32'h04, 32'd0, 4'hF, 32'hFFFF_FFFF, 8'h00, "oeb0_after_sel3");
        check("oeb_after_sel3", 64'(io_oeb), 64'(38'h3F_FFFF_FFFF));
        bus(1'b1, BASE + 32'h04, 32'h0, 4'hF, 32'h0, 8'h00, "oeb0_selF");
        check("oeb_after_selF", 64'(io_oeb), 64'(38'h3F_0000_0000));
        bus(1'b1, BASE + 32'h08, 32'h15, 4'hF, 32'h0, 8'h00, "oeb1_wr");
        check("oeb_after_oeb1", 64'(io_oeb), 64'(38'h15_0000_0000));

        // Switch to project 3 and time the forced-pad window.
        bus(1'b1, BASE + 32'h00, 32'd3, 4'hF, 32'h0, 8'h00, "active_wr3");
        t0 = ack_cyc;
        check("drain_oeb", 64'(io_oeb), 64'(38'h3F_FFFF_FFFF));
        check("drain_io_out", 64'(io_out), 64'd0);
        check("drain_reset", 64'(proj_reset), 64'hFF);
        bus(1'b0, BASE + 32'h0C, 32'd0, 4'hF, 32'h0000_0100, 8'h00, "status_busy");
        wait_unforced(t1);
        check("forced_cycles", 64'(t1 - t0), 64'(2 * H + 1));
        check("first_run_io_out", 64'(io_out), 64'd0);
        check("sw3_reset", 64'(proj_reset), 64'hF7);
        check("sw3_clk_en", 64'(proj_clk_en), 64'h08);
        @(negedge clk);
        check("sw3_io_out", 64'(io_out), 64'(io_pat(3)));
        bus(1'b0, BASE + 32'h0C, 32'd0, 4'hF, 32'h0000_0003, 8'h00, "status_p3");

        // Out-of-range, busy and same-index ACTIVE writes are ignored.
        bus(1'b1, BASE + 32'h00, 32'd9, 4'hF, 32'h0, 8'h00, "active_wr9");
        bus(1'b0, BASE + 32'h0C, 32'd0, 4'hF, 32'h0000_0003, 8'h00, "status_after9");
        bus(1'b1, BASE + 32'h00, 32'd1, 4'hF, 32'h0, 8'h00, "active_wr1");
        bus(1'b1, BASE + 32'h00, 32'd5, 4'hF, 32'h0, 8'h00, "active_wr5_busy");
        wait_unforced(t1);
        bus(1'b0, BASE + 32'h0C, 32'd0, 4'hF, 32'h0000_0001, 8'h00, "status_p1");
        bus(1'b1, BASE + 32'h00, 32'd1, 4'hF, 32'h0, 8'h00, "active_wr_same");
        bus(1'b0, BASE + 32'h0C, 32'd0, 4'hF, 32'h0000_0001, 8'h00, "status_same");
        check("p1_io_out", 64'(io_out), 64'(io_pat(1)));

        // Project windows.
        bus(1'b1, BASE + 32'h304, 32'hA5, 4'hF, 32'h0, 8'h04, "win2_wr");
        bus(1'b0, BASE + 32'h500, 32'd0, 4'hF, 32'hDA7A_0004, 8'h00, "win4_rd");
        bus(1'b0, BASE + 32'h8FC, 32'd0, 4'hF, 32'hDA7A_0007, 8'h00, "win7_rd");
        bus(1'b1, BASE + 32'h100, 32'h1, 4'h1, 32'h0, 8'h01, "win0_wr");

        // Reset in the middle of a switch.
        bus(1'b1, BASE + 32'h00, 32'd6, 4'hF, 32'h0, 8'h00, "active_wr6");
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (H + 2) @(posedge clk);
        #1;
        check("post_rst_reset", 64'(proj_reset), 64'hFE);
        check("post_rst_io_out", 64'(io_out), 64'(io_pat(0)));
        check("post_rst_oeb", 64'(io_oeb), 64'(38'h3F_FFFF_FFFF));
        bus(1'b0, BASE + 32'h0C, 32'd0, 4'hF, 32'h0000_0000, 8'h00, "status_post_rst");
        bus(1'b0, BASE + 32'h04, 32'd0, 4'hF, 32'hFFFF_FFFF, 8'h00, "oeb0_post_rst");

        repeat (4) @(posedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
